// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter with lock in front of a single-port synchronous RAM.
// Define ARB_RR_EN for round-robin contention; otherwise port 0 wins contention.
module ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_nxt;
    logic   g0, g1;
    logic   rv0, rv1;
    logic   ptr;

`ifdef ARB_RR_EN
    // Pointer follows the last unlocked transfer, so a lock owner hands priority to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (g0 && !m0_lock)
            ptr <= 1'b1;
        else if (g1 && !m1_lock)
            ptr <= 1'b0;
    end
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || !ptr))
                    g0 = 1'b1;
                else if (m1_req)
                    g1 = 1'b1;
            end
            LOCK0:   g0 = m0_req;
            LOCK1:   g1 = m1_req;
            default: ;
        endcase
        // Grants must read 0 for the whole time reset is held, not just after the next edge.
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
        if (g0)
            state_nxt = m0_lock ? LOCK0 : IDLE;
        else if (g1)
            state_nxt = m1_lock ? LOCK1 : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            state <= state_nxt;
            rv0   <= g0 && !m0_we;
            rv1   <= g1 && !m1_we;
        end
    end

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

    assign ram_we   = g0 ? m0_we    : (g1 ? m1_we    : 1'b0);
    assign ram_addr = g0 ? m0_addr  : (g1 ? m1_addr  : '0);
    assign ram_din  = g0 ? m0_wdata : (g1 ? m1_wdata : '0);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural RAM and arbiter model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] ram_addr, ram_din, ram_dout;
    logic        ram_we;

    logic [15:0] ram  [0:65535];
    logic [15:0] refm [0:65535];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        m0_req = 1; m0_we = 1; m0_addr = 16'h1111; m0_wdata = 16'h2222;
        m1_req = 1; m1_we = 1; m1_addr = 16'h3333; m1_wdata = 16'h4444;
        #1;
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt got %b want 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt got %b want 0", m1_gnt); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        checks++; if (ram_addr !== 16'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_din !== 16'h0) begin errors++; $display("FAIL reset_ram_din got %h want 0", ram_din); end
        step();
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {m0_rvalid, m1_rvalid}); end
        idle_inputs();
        @(negedge clk); rst_n = 1;
        step();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_addr = 16'd32;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt got %b want 1", m0_gnt); end
        step();
        idle_inputs();
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b want 1", m0_rvalid); end
        checks++; if (m0_rdata !== 16'd3) begin errors++; $display("FAIL single_rdata got %h want 0003", m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid got %b want 0", m1_rvalid); end
        step();
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_drop got %b want 0", m0_rvalid); end
    endtask

    task automatic test_write_read();
        m1_req = 1; m1_we = 1; m1_addr = 16'h0040; m1_wdata = 16'hABCD;
        #1;
        checks++; if (ram_we !== 1'b1 || m1_gnt !== 1'b1) begin errors++; $display("FAIL wr_cycle we=%b gnt=%b want 1 1", ram_we, m1_gnt); end
        step();
        m1_we = 0; m1_wdata = 0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_cycle_we got %b want 0", ram_we); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b want 0", m1_rvalid); end
        step();
        idle_inputs();
        #1;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'hABCD) begin errors++; $display("FAIL raw_rdata rvalid=%b data=%h want 1 abcd", m1_rvalid, m1_rdata); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL raw_we_after got %b want 0", ram_we); end
        step();
    endtask

    task automatic test_contention();
        logic [1:0] last;
        last = 2'b00;
        for (int c = 0; c < 7; c++) begin
            logic [1:0] want;
            m0_req = (c < 6); m0_addr = 16'h0200 + 16'(c);
            m1_req = (c < 6); m1_addr = 16'h0300 + 16'(c);
`ifdef ARB_RR_EN
            want = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
`else
            want = (c >= 6) ? 2'b00 : 2'b01;
`endif
            #1;
            checks++; if ({m1_gnt, m0_gnt} !== want) begin errors++; $display("FAIL contention_gnt cyc %0d got %b want %b", c, {m1_gnt, m0_gnt}, want); end
            checks++; if ({m1_rvalid, m0_rvalid} !== last) begin errors++; $display("FAIL contention_tag cyc %0d got %b want %b", c, {m1_rvalid, m0_rvalid}, last); end
            last = want;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        m1_req = 1; m1_lock = 1; m1_addr = 16'h0080;
        #1;
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL lock_first_gnt got %b want 1", m1_gnt); end
        step();
        m1_req = 0; m1_lock = 0;
        m0_req = 1; m0_addr = 16'h0010;
        #1;
        checks++; if (m0_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h0) begin errors++; $display("FAIL lock_gap gnt=%b we=%b addr=%h want 0 0 0", m0_gnt, ram_we, ram_addr); end
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h1234) begin errors++; $display("FAIL lock_rdata rvalid=%b data=%h want 1 1234", m1_rvalid, m1_rdata); end
        step();
        m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 16'h0080; m1_wdata = 16'h1235;
        #1;
        checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin errors++; $display("FAIL lock_release gnt0=%b gnt1=%b want 0 1", m0_gnt, m1_gnt); end
        step();
        m1_req = 0; m1_we = 0;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL lock_after got %b want 1", m0_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_midlock();
        m0_req = 1; m0_lock = 1; m0_addr = 16'd32;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL midlock_gnt got %b want 1", m0_gnt); end
        step();
        m0_lock = 0;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL midlock_pending got %b want 1", m0_rvalid); end
        #2 rst_n = 0;
        #1;
        checks++; if ({m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid} !== 5'b0) begin errors++; $display("FAIL midlock_async got %b want 00000", {m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid}); end
        idle_inputs();
        @(negedge clk); rst_n = 1;
        step();
        m1_req = 1; m1_addr = 16'h0040;
        #1;
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL midlock_m1_after got %b want 1", m1_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (ram_we !== 1'b0 || ram_addr !== 16'h0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
                errors++; $display("FAIL idle cyc %0d we=%b addr=%h rv=%b%b want 0 0 00", c, ram_we, ram_addr, m0_rvalid, m1_rvalid);
            end
            checks++; if ($isunknown(m0_rdata) || $isunknown(m1_rdata)) begin errors++; $display("FAIL idle_rdata_x cyc %0d got %h %h want known", c, m0_rdata, m1_rdata); end
            step();
        end
    endtask

    task automatic test_random();
        logic        pr[2], pw[2], pl[2];
        logic [15:0] pa[2], pd[2];
        logic        erv[2], nrv[2];
        logic [15:0] erd[2], nrd[2];
        int          own, prio, w;
        for (int i = 0; i < 65536; i++) refm[i] = ram[i];
        own = -1; prio = 0;
        for (int p = 0; p < 2; p++) begin pr[p] = 0; erv[p] = 0; erd[p] = 0; end
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p] && $urandom_range(0, 9) < 6) begin
                    pr[p] = 1; pw[p] = 1'($urandom_range(0, 1)); pl[p] = ($urandom_range(0, 3) == 0);
                    pa[p] = 16'h0100 + 16'($urandom_range(0, 7)); pd[p] = 16'($urandom);
                end
            end
            m0_req = pr[0]; m0_we = pw[0]; m0_lock = pl[0]; m0_addr = pa[0]; m0_wdata = pd[0];
            m1_req = pr[1]; m1_we = pw[1]; m1_lock = pl[1]; m1_addr = pa[1]; m1_wdata = pd[1];
            #1;
            if (own >= 0) w = pr[own] ? own : -1;
            else if (pr[0] && pr[1]) w = prio;
            else if (pr[0]) w = 0;
            else if (pr[1]) w = 1;
            else w = -1;
            checks++; if (m0_gnt !== (w == 0) || m1_gnt !== (w == 1)) begin errors++; $display("FAIL rand_gnt cyc %0d got %b%b want %b%b", c, m1_gnt, m0_gnt, w == 1, w == 0); end
            checks++; if (ram_we !== ((w >= 0) ? pw[w] : 1'b0) || ram_addr !== ((w >= 0) ? pa[w] : 16'h0) || ram_din !== ((w >= 0) ? pd[w] : 16'h0)) begin
                errors++; $display("FAIL rand_ram cyc %0d got we=%b a=%h d=%h winner=%0d", c, ram_we, ram_addr, ram_din, w);
            end
            checks++; if (m0_rvalid !== erv[0] || m1_rvalid !== erv[1]) begin errors++; $display("FAIL rand_rvalid cyc %0d got %b%b want %b%b", c, m1_rvalid, m0_rvalid, erv[1], erv[0]); end
            if (erv[0]) begin checks++; if (m0_rdata !== erd[0]) begin errors++; $display("FAIL rand_rdata0 cyc %0d got %h want %h", c, m0_rdata, erd[0]); end end
            if (erv[1]) begin checks++; if (m1_rdata !== erd[1]) begin errors++; $display("FAIL rand_rdata1 cyc %0d got %h want %h", c, m1_rdata, erd[1]); end end
            nrv[0] = 0; nrv[1] = 0; nrd[0] = 0; nrd[1] = 0;
            if (w >= 0) begin
                if (pw[w]) refm[pa[w]] = pd[w];
                else begin nrv[w] = 1; nrd[w] = refm[pa[w]]; end
                own = pl[w] ? w : -1;
`ifdef ARB_RR_EN
                if (!pl[w]) prio = 1 - w;
`endif
                pr[w] = 0;
            end
            step();
            erv = nrv; erd = nrd;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        ram[32]     = 16'd3;
        ram[16'h80] = 16'h1234;
        ram_dout    = 16'h0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_read();
        do_reset();
        test_contention();
        test_lock();
        test_reset_midlock();
        test_idle();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
